// File: rtl/vram_pkg.sv
// Shared constants and types for the dual-port video RAM.
//   H_RES_DEF / V_RES_DEF : default frame geometry (pixels per line, lines)
//   PIX_W_DEF             : default bits per pixel, packed |r|g|b|, MSB first
//   CH_W, *_LSB           : per-channel field width and bit positions
//   fill_state_t          : whole-frame fill engine states
package vram_pkg;

    localparam int unsigned H_RES_DEF = 200;
    localparam int unsigned V_RES_DEF = 150;
    localparam int unsigned PIX_W_DEF = 9;

    localparam int unsigned CH_W  = PIX_W_DEF / 3;
    localparam int unsigned R_LSB = 2 * CH_W;
    localparam int unsigned G_LSB = CH_W;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/vga_vram_dp_if.sv
// Bus between the game logic / VGA scanner (master) and the video RAM (slave).
//   write : wr_valid, wr_x, wr_y, wr_data -> wr_ready, wr_err
//   read  : rd_en, rd_x, rd_y             -> rd_data, rd_valid
//   fill  : fill_start, fill_color        -> fill_busy, fill_done
interface vga_vram_dp_if
    import vram_pkg::*;
#(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 8,
    parameter int unsigned PIX_W = PIX_W_DEF
) ();

    logic             wr_valid;
    logic             wr_ready;
    logic [X_W-1:0]   wr_x;
    logic [Y_W-1:0]   wr_y;
    logic [PIX_W-1:0] wr_data;
    logic             wr_err;

    logic             rd_en;
    logic [X_W-1:0]   rd_x;
    logic [Y_W-1:0]   rd_y;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;

    logic             fill_start;
    logic [PIX_W-1:0] fill_color;
    logic             fill_busy;
    logic             fill_done;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y,
               fill_start, fill_color,
        input  wr_ready, wr_err, rd_data, rd_valid, fill_busy, fill_done
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y,
               fill_start, fill_color,
        output wr_ready, wr_err, rd_data, rd_valid, fill_busy, fill_done
    );

endinterface

// File: rtl/vram_addr_calc.sv
// Pixel coordinate to linear address: addr = y*H_RES + x, full ADDR_W width.
//   x, y     : pixel column / row
//   addr     : linear address (meaningful only when in_range)
//   in_range : x < H_RES and y < V_RES
module vram_addr_calc #(
    parameter int unsigned H_RES  = 200,
    parameter int unsigned V_RES  = 150,
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    always_comb begin
        addr     = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
        in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
    end

endmodule

// File: rtl/vga_vram_dp.sv
// Dual-port video RAM: game-logic write port, VGA-scanner read port, and a
// whole-frame fill engine writing one pixel per cycle.
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : vga_vram_dp_if slave (write / read / fill groups)
// Writes stall (wr_ready=0) only while the fill runs; reads never stall and
// are read-first with one cycle of latency.
module vga_vram_dp
    import vram_pkg::*;
#(
    parameter int unsigned H_RES  = H_RES_DEF,
    parameter int unsigned V_RES  = V_RES_DEF,
    parameter int unsigned PIX_W  = PIX_W_DEF,
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_vram_dp_if.slave bus
);

    localparam int unsigned DEPTH  = H_RES * V_RES;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              wr_in_range, rd_in_range;

    fill_state_t       state, state_nxt;
    logic [MEM_AW-1:0] fill_cnt;
    logic [PIX_W-1:0]  fill_col;
    logic              fill_busy, fill_done, fill_go;

    logic              rst_done, wr_ready, wr_fire;
    logic              wr_err_q, rd_valid_q;
    logic [PIX_W-1:0]  rd_data_q;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem [DEPTH];

    vram_addr_calc #(
        .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) u_wr_addr (
        .x(bus.wr_x), .y(bus.wr_y), .addr(wr_addr), .in_range(wr_in_range)
    );

    vram_addr_calc #(
        .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) u_rd_addr (
        .x(bus.rd_x), .y(bus.rd_y), .addr(rd_addr), .in_range(rd_in_range)
    );

    // In-range addresses are below DEPTH, so only the low MEM_AW bits index
    // the array; the upper bits are deliberately dropped.
    generate
        if (ADDR_W > MEM_AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^{wr_addr[ADDR_W-1:MEM_AW], rd_addr[ADDR_W-1:MEM_AW]};
        end
    endgenerate

    // Fill FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Fill FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.fill_start) state_nxt = FILL;
            FILL:    if (fill_cnt == MEM_AW'(DEPTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fill FSM: outputs
    always_comb begin
        fill_busy = 1'b0;
        fill_done = 1'b0;
        fill_go   = 1'b0;
        case (state)
            IDLE:    fill_go   = bus.fill_start;
            FILL:    fill_busy = 1'b1;
            DONE:    fill_done = 1'b1;
            default: ;
        endcase
    end

    // rst_done keeps wr_ready low while reset is held.
    assign wr_ready = rst_done && !fill_busy;
    assign wr_fire  = bus.wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
            wr_err_q <= 1'b0;
            fill_cnt <= '0;
            fill_col <= '0;
        end else begin
            rst_done <= 1'b1;
            wr_err_q <= wr_fire && !wr_in_range;
            if (fill_go) begin
                fill_col <= bus.fill_color;
                fill_cnt <= '0;
            end else if (fill_busy) begin
                fill_cnt <= fill_cnt + MEM_AW'(1);
            end
        end
    end

    // Single write port shared by the fill engine and the user side; they
    // never collide because wr_ready is low for the whole fill.
    always_comb begin
        mem_we    = fill_busy || (wr_fire && wr_in_range);
        mem_waddr = fill_busy ? fill_cnt : wr_addr[MEM_AW-1:0];
        mem_wdata = fill_busy ? fill_col : bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_in_range ? mem[rd_addr[MEM_AW-1:0]] : '0;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.wr_err    = wr_err_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.fill_busy = fill_busy;
    assign bus.fill_done = fill_done;

endmodule

// File: tb/tb_vga_vram_dp.sv
// Self-checking bench for vga_vram_dp: directed steps plus $urandom traffic
// compared against a frame-array reference model held in the bench.
module tb_vga_vram_dp;

    localparam int H     = 200;
    localparam int V     = 150;
    localparam int DEPTH = H * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_vram_dp_if #(.X_W(8), .Y_W(8), .PIX_W(9)) bus ();

    vga_vram_dp #(
        .H_RES(H), .V_RES(V), .PIX_W(9), .X_W(8), .Y_W(8), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Reference model: frame contents plus a "value is defined" flag.
    logic [8:0] ref_mem   [DEPTH];
    bit         ref_known [DEPTH];
    logic [8:0] exp_rd;
    bit         exp_rd_known;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    function automatic bit in_frame(input int x, input int y);
        return (x < H) && (y < V);
    endfunction

    function automatic int lin(input int x, input int y);
        return y * H + x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_x       = '0;
        bus.wr_y       = '0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_x       = '0;
        bus.rd_y       = '0;
        bus.fill_start = 1'b0;
        bus.fill_color = '0;
    endtask

    // Predict the read result from the model (old contents: read-first).
    task automatic predict_read(input int rx, input int ry);
        if (in_frame(rx, ry)) begin
            exp_rd       = ref_mem[lin(rx, ry)];
            exp_rd_known = ref_known[lin(rx, ry)];
        end else begin
            exp_rd       = '0;
            exp_rd_known = 1'b1;
        end
    endtask

    // One cycle with optional write and read, checked against the model.
    task automatic step(input string tag, input bit wv, input int wx, input int wy,
                        input logic [8:0] wd, input bit re, input int rx, input int ry);
        bus.wr_valid = wv;
        bus.wr_x     = 8'(wx);
        bus.wr_y     = 8'(wy);
        bus.wr_data  = wd;
        bus.rd_en    = re;
        bus.rd_x     = 8'(rx);
        bus.rd_y     = 8'(ry);
        if (wv) check({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'd1);
        if (re) predict_read(rx, ry);
        tick();
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(re));
        if (exp_rd_known) check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
        check({tag, ".wr_err"}, 32'(bus.wr_err), 32'(wv && !in_frame(wx, wy)));
        if (wv && in_frame(wx, wy)) begin
            ref_mem[lin(wx, wy)]   = wd;
            ref_known[lin(wx, wy)] = 1'b1;
        end
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    // Whole-frame fill with a read every cycle and ignored writes / restarts.
    // abort_at >= 0 asserts reset after that many fill cycles.
    task automatic run_fill(input string tag, input logic [8:0] color,
                            input bit with_write, input int abort_at);
        int busy_n = 0, done_n = 0, busy_bad = 0, ready_bad = 0;
        int valid_bad = 0, data_bad = 0, last_i = 0;
        int rx, ry;
        bus.fill_start = 1'b1;
        bus.fill_color = color;
        if (with_write) begin
            bus.wr_valid = 1'b1;
            bus.wr_x     = 8'd3;
            bus.wr_y     = 8'd3;
            bus.wr_data  = 9'h055;
            check({tag, ".start_wr_ready"}, 32'(bus.wr_ready), 32'd1);
        end
        tick();
        if (with_write) begin
            ref_mem[lin(3, 3)]   = 9'h055;
            ref_known[lin(3, 3)] = 1'b1;
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i <= DEPTH + 1; i++) begin
            last_i = i;
            if (bus.fill_busy === 1'b1) busy_n++;
            if (bus.fill_done === 1'b1) done_n++;
            if (bus.fill_busy !== (i < DEPTH)) busy_bad++;
            if (bus.wr_ready !== (i >= DEPTH)) ready_bad++;
            if (i > 0) begin
                if (bus.rd_valid !== 1'b1) valid_bad++;
                if (exp_rd_known && bus.rd_data !== exp_rd) data_bad++;
            end
            if (i == abort_at) break;
            rx = ($urandom_range(0, 15) == 0) ? int'($urandom_range(H, 255)) : int'($urandom_range(0, H - 1));
            ry = int'($urandom_range(0, V - 1));
            if (i == DEPTH - 1) begin
                rx = H - 1;
                ry = V - 1;
            end
            bus.rd_en = 1'b1;
            bus.rd_x  = 8'(rx);
            bus.rd_y  = 8'(ry);
            predict_read(rx, ry);
            bus.fill_start = (i == 1000) || (i == DEPTH);
            bus.fill_color = ~color;
            bus.wr_valid   = (i < DEPTH) && ($urandom_range(0, 3) == 0);
            bus.wr_x       = 8'($urandom_range(0, H - 1));
            bus.wr_y       = 8'($urandom_range(0, V - 1));
            bus.wr_data    = 9'($urandom);
            tick();
            if (i < DEPTH) begin
                ref_mem[i]   = color;
                ref_known[i] = 1'b1;
            end
        end
        idle_inputs();
        check({tag, ".busy_flag"}, 32'(busy_bad), 32'd0);
        check({tag, ".wr_ready_low"}, 32'(ready_bad), 32'd0);
        check({tag, ".rd_valid_cont"}, 32'(valid_bad), 32'd0);
        check({tag, ".rd_data_cont"}, 32'(data_bad), 32'd0);
        if (abort_at >= 0) begin
            check({tag, ".abort_point"}, 32'(last_i), 32'(abort_at));
            check({tag, ".busy_before_abort"}, 32'(busy_n), 32'(abort_at + 1));
            rst_n = 1'b0;
            #1;
            check({tag, ".rst_busy"}, 32'(bus.fill_busy), 32'd0);
            check({tag, ".rst_wr_ready"}, 32'(bus.wr_ready), 32'd0);
            check({tag, ".rst_rd_valid"}, 32'(bus.rd_valid), 32'd0);
            for (int k = 0; k < 3; k++) begin
                if (bus.fill_done !== 1'b0) done_n++;
                tick();
            end
            check({tag, ".no_done"}, 32'(done_n), 32'd0);
            rst_n = 1'b1;
            tick();
            check({tag, ".release_wr_ready"}, 32'(bus.wr_ready), 32'd1);
            check({tag, ".release_busy"}, 32'(bus.fill_busy), 32'd0);
            for (int a = 0; a < DEPTH; a++) ref_known[a] = 1'b0;
            exp_rd       = '0;
            exp_rd_known = 1'b1;
        end else begin
            check({tag, ".busy_cycles"}, 32'(busy_n), 32'(DEPTH));
            check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        end
    endtask

    initial begin
        int wx, wy, rx, ry;
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a]   = '0;
            ref_known[a] = 1'b0;
        end
        exp_rd       = '0;
        exp_rd_known = 1'b1;

        // Reset state, with requests driven to show they are ignored.
        bus.rd_en    = 1'b1;
        bus.wr_valid = 1'b1;
        tick();
        tick();
        check("rst.wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst.wr_err", 32'(bus.wr_err), 32'd0);
        check("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst.rd_data", 32'(bus.rd_data), 32'd0);
        check("rst.fill_busy", 32'(bus.fill_busy), 32'd0);
        check("rst.fill_done", 32'(bus.fill_done), 32'd0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        check("rst.release_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Basic write/read and addressing neighbours.
        step("t1.wr",   1, 5, 2, 9'h1C7, 0, 0, 0);
        step("t1.wr_n", 1, 6, 2, 9'h0F0, 0, 0, 0);
        step("t1.wr_s", 1, 5, 3, 9'h00F, 0, 0, 0);
        step("t1.rd",   0, 0, 0, 9'h000, 1, 5, 2);
        step("t1.hold", 0, 0, 0, 9'h000, 0, 0, 0);
        step("t1.rd_n", 0, 0, 0, 9'h000, 1, 6, 2);
        step("t1.rd_s", 0, 0, 0, 9'h000, 1, 5, 3);

        // Out-of-range writes and reads.
        step("t2.wr0",   1, 0,   0,   9'h0A5, 0, 0, 0);
        step("t2.wrL",   1, 199, 149, 9'h15A, 0, 0, 0);
        step("t2.oob_x", 1, 200, 0,   9'h1FF, 0, 0, 0);
        step("t2.gap",   0, 0,   0,   9'h000, 0, 0, 0);
        step("t2.oob_y", 1, 0,   150, 9'h1FF, 0, 0, 0);
        step("t2.gap2",  0, 0,   0,   9'h000, 0, 0, 0);
        step("t2.rd0",   0, 0,   0,   9'h000, 1, 0, 0);
        step("t2.rdL",   0, 0,   0,   9'h000, 1, 199, 149);
        step("t2.rd_oob", 0, 0,  0,   9'h000, 1, 210, 3);

        // Read-first collision.
        step("t3.pre",  1, 10, 10, 9'h111, 0, 0, 0);
        step("t3.coll", 1, 10, 10, 9'h0AA, 1, 10, 10);
        step("t3.post", 0, 0,  0,  9'h000, 1, 10, 10);

        // Random traffic in a small window with occasional out-of-range use.
        for (int n = 0; n < 300; n++) begin
            wx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(H, 255)) : int'($urandom_range(0, 7));
            wy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(V, 255)) : int'($urandom_range(0, 7));
            rx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(H, 255)) : int'($urandom_range(0, 7));
            ry = ($urandom_range(0, 7) == 0) ? int'($urandom_range(V, 255)) : int'($urandom_range(0, 7));
            step("rnd", 1'($urandom_range(0, 1)), wx, wy, 9'($urandom),
                 1'($urandom_range(0, 1)), rx, ry);
        end

        // Full fill, started together with a write that the fill overwrites.
        run_fill("t4", 9'h124, 1'b1, -1);
        step("t4.rd00",   0, 0, 0, 9'h000, 1, 0,   0);
        step("t4.rdL",    0, 0, 0, 9'h000, 1, 199, 149);
        step("t4.rdM",    0, 0, 0, 9'h000, 1, 100, 75);
        step("t4.rd33",   0, 0, 0, 9'h000, 1, 3,   3);
        step("t4.wr_ok",  1, 7, 7, 9'h0C3, 0, 0,   0);
        step("t4.rd77",   0, 0, 0, 9'h000, 1, 7,   7);

        // Reset mid-fill, then a clean zero fill.
        run_fill("t6.abort", 9'h1B6, 1'b0, 1000);
        run_fill("t6.zero", 9'h000, 1'b0, -1);
        for (int a = 0; a < DEPTH; a += 37) step("t6.frame", 0, 0, 0, 9'h000, 1, a % H, a / H);
        step("t6.frame_last", 0, 0, 0, 9'h000, 1, H - 1, V - 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
